// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, credit-limited reads from a synchronous instruction memory, and an instruction queue.
// Define IFETCH_STATS_EN to add the fetch_count_o / bubble_count_o statistics counters.
package instr_fetch_pkg;
  typedef logic [31:0] instruction_s;
endpackage

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter logic [addr_width_p-1:0] boot_addr_p = '0,
  parameter int depth_p = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [addr_width_p-1:0] imem_addr_o,
  input  logic                    imem_wen_i,
  input  instruction_s            imem_instr_i,
  input  logic                    redirect_v_i,
  input  logic [addr_width_p-1:0] redirect_addr_i,
  output logic                    instr_v_o,
  output instruction_s            instr_o,
  output logic [addr_width_p-1:0] instr_pc_o,
  input  logic                    instr_ready_i
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]             fetch_count_o,
  output logic [31:0]             bubble_count_o
`endif
);
  localparam int pw = depth_p > 1 ? $clog2(depth_p) : 1;
  localparam int cw = $clog2(depth_p + 1);
  logic [addr_width_p-1:0] pc, inflight_pc;
  logic                    inflight;
  logic [cw-1:0]           count;
  logic [cw:0]             used;
  logic [pw-1:0]           head, tail;
  instruction_s            q_instr [depth_p];
  logic [addr_width_p-1:0] q_pc    [depth_p];
  logic                    issue, push, pop;

  function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
    return p == pw'(depth_p - 1) ? '0 : p + 1'b1;
  endfunction

  // Credits returned by this cycle's pop count, so a full-rate stream never stalls.
  assign used        = {1'b0, count} + (cw+1)'(inflight) - (cw+1)'(pop);
  assign issue       = !imem_wen_i && !redirect_v_i && used < (cw+1)'(depth_p);
  assign push        = inflight && !redirect_v_i;
  assign pop         = instr_v_o && instr_ready_i;
  assign imem_addr_o = pc;
  assign instr_v_o   = count != '0;
  assign instr_o     = q_instr[head];
  assign instr_pc_o  = q_pc[head];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc       <= boot_addr_p;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_v_i) begin
      pc       <= redirect_addr_i;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= issue;
      pc       <= issue ? pc + 1'b1 : pc;
      tail     <= push ? nxt(tail) : tail;
      head     <= pop ? nxt(head) : head;
      count    <= count + cw'(push) - cw'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= pc;
    if (push) begin
      q_instr[tail] <= imem_instr_i;
      q_pc[tail]    <= inflight_pc;
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_count_o  <= '0;
      bubble_count_o <= '0;
    end else begin
      fetch_count_o  <= fetch_count_o + 32'(push);
      bubble_count_o <= bubble_count_o + 32'(!instr_v_o && instr_ready_i);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed timing scenarios plus random traffic checked against an in-order PC stream model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         reset_n, imem_wen_i, redirect_v_i, instr_v_o, instr_ready_i;
  logic [9:0]   imem_addr_o, redirect_addr_i, instr_pc_o;
  instruction_s imem_instr_i, instr_o;
`ifdef IFETCH_STATS_EN
  logic [31:0]  fetch_count_o, bubble_count_o;
`endif
  instr_fetch dut (
    .clk(clk), .reset_n(reset_n), .imem_addr_o(imem_addr_o), .imem_wen_i(imem_wen_i),
    .imem_instr_i(imem_instr_i), .redirect_v_i(redirect_v_i), .redirect_addr_i(redirect_addr_i),
    .instr_v_o(instr_v_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
`ifdef IFETCH_STATS_EN
    , .fetch_count_o(fetch_count_o), .bubble_count_o(bubble_count_o)
`endif
  );
  logic [31:0] mem [1024];
  always @(posedge clk) imem_instr_i <= imem_wen_i ? (32'hDEAD_0000 ^ $urandom) : mem[imem_addr_o];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic rdy, input logic w, input logic rv, input logic [9:0] a);
    @(posedge clk);
    #1;
    reset_n = rn;
    instr_ready_i = rdy;
    imem_wen_i = w;
    redirect_v_i = rv;
    redirect_addr_i = a;
    @(negedge clk);
  endtask

  // Consumer-side model: handshakes must see consecutive PCs from the last reset or redirect target.
  logic [9:0]  exp_pc = 10'd0;
  logic        prev_flush = 1'b0;
  logic        prev_hold = 1'b0;
  logic [9:0]  prev_pc;
  logic [31:0] prev_instr;
  int          starve = 0;
  always @(negedge clk) begin
    if (prev_flush) chk("flush_v", instr_v_o, 1'b0);
    if (prev_hold) begin
      chk("hold_v", instr_v_o, 1'b1);
      chk("hold_pc", instr_pc_o, prev_pc);
      chk("hold_instr", instr_o, prev_instr);
    end
    if (!reset_n || redirect_v_i || imem_wen_i) starve = 0;
    else if (instr_ready_i && !instr_v_o) starve++;
    if (reset_n) chk("starve", starve <= 2, 1'b1);
    if (reset_n && instr_v_o && instr_ready_i) begin
      chk("pc", instr_pc_o, exp_pc);
      chk("instr", instr_o, mem[exp_pc]);
      exp_pc = exp_pc + 10'd1;
    end
    if (!reset_n) exp_pc = 10'd0;
    else if (redirect_v_i) exp_pc = redirect_addr_i;
    prev_flush = !reset_n || redirect_v_i;
    prev_hold = reset_n && !redirect_v_i && instr_v_o && !instr_ready_i;
    prev_pc = instr_pc_o;
    prev_instr = instr_o;
  end

  logic [9:0] seen [$];
  logic [9:0] e4 [3];
  initial begin
    reset_n = 1'b0;
    instr_ready_i = 1'b1;
    imem_wen_i = 1'b0;
    redirect_v_i = 1'b0;
    redirect_addr_i = '0;
    for (int k = 0; k < 1024; k++) mem[k] = ($urandom << 10) | 32'(k);
    e4 = '{10'h3FE, 10'h3FF, 10'h000};
    cyc(0, 1, 0, 0, 0);
    chk("rst_v", instr_v_o, 1'b0);
    chk("rst_addr", imem_addr_o, 10'd0);
    cyc(0, 1, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      cyc(1, 1, 0, 0, 0);
      chk("d1_v", instr_v_o, c >= 2);
      if (c >= 2) chk("d1_pc", instr_pc_o, 32'(c - 2));
    end
    cyc(0, 1, 0, 0, 0);
    for (int c = 0; c < 5; c++) cyc(1, 0, 0, 0, 0);
    chk("d2_v", instr_v_o, 1'b1);
    chk("d2_pc", instr_pc_o, 10'd0);
    chk("d2_addr", imem_addr_o, 10'd2);
    cyc(1, 1, 0, 0, 0);
    chk("d2_first", instr_pc_o, 10'd0);
    cyc(1, 0, 0, 0, 0);
    chk("d2_second_v", instr_v_o, 1'b1);
    chk("d2_second", instr_pc_o, 10'd1);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 10'h3F0);
    cyc(1, 1, 0, 0, 0);
    chk("d3_v0", instr_v_o, 1'b0);
    cyc(1, 1, 0, 0, 0);
    chk("d3_v1", instr_v_o, 1'b0);
    cyc(1, 1, 0, 0, 0);
    chk("d3_v2", instr_v_o, 1'b1);
    chk("d3_pc", instr_pc_o, 10'h3F0);
    cyc(1, 1, 0, 1, 10'h3FE);
    for (int c = 0; c < 5; c++) begin
      cyc(1, 1, 0, 0, 0);
      chk("d4_v", instr_v_o, c >= 2);
      if (c >= 2) chk("d4_pc", instr_pc_o, e4[c-2]);
    end
    for (int c = 0; c < 11; c++) begin
      cyc(1, 1, c >= 2 && c < 5, 0, 0);
      if (instr_v_o) seen.push_back(instr_pc_o);
    end
    chk("d5_n", seen.size(), 8);
    for (int i = 1; i < seen.size(); i++) chk("d5_seq", seen[i], seen[i-1] + 10'd1);
    cyc(1, 1, 0, 1, 10'd0);
    for (int c = 0; c < 9; c++) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("d6_pc7", instr_pc_o, 10'd7);
    cyc(1, 1, 0, 0, 0);
    chk("d6_v0", instr_v_o, 1'b0);
    cyc(1, 1, 0, 0, 0);
    chk("d6_v1", instr_v_o, 1'b0);
    cyc(1, 1, 0, 0, 0);
    chk("d6_v2", instr_v_o, 1'b1);
    chk("d6_boot", instr_pc_o, 10'd0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 1) ? 10'(10'h3F8 + $urandom_range(0, 7)) : 10'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
